// File: rtl/dbus_bridge_if.sv
// -----------------------------------------------------------------------------
// dbus_bridge_if
//
// Purpose:
//   Groups the data-bus signals around the bridge. One side is the pipelined
//   core's MEM-stage data port. The other side is the external asynchronous
//   data RAM.
//
// Signals:
//   daddr     [9:0]   core data byte address
//   ddata_w   [31:0]  core write data
//   d_rw              core write enable (1 = write)
//   ddata_r   [31:0]  read data returned to the core (combinational)
//   ram_addr  [7:0]   RAM word address
//   ram_d     [31:0]  RAM write data
//   ram_we            RAM write enable
//   ram_q     [31:0]  RAM read data (asynchronous RAM)
//
// Modports:
//   master : the environment around the bridge (core plus RAM). It drives
//            the core request and the RAM read data.
//   slave  : the bridge itself.
// -----------------------------------------------------------------------------
interface dbus_bridge_if;
  logic [9:0]  daddr;
  logic [31:0] ddata_w;
  logic        d_rw;
  logic [31:0] ddata_r;
  logic [7:0]  ram_addr;
  logic [31:0] ram_d;
  logic        ram_we;
  logic [31:0] ram_q;

  modport master (
    output daddr, ddata_w, d_rw, ram_q,
    input  ddata_r, ram_addr, ram_d, ram_we
  );

  modport slave (
    input  daddr, ddata_w, d_rw, ram_q,
    output ddata_r, ram_addr, ram_d, ram_we
  );
endinterface

// File: rtl/dbus_bridge.sv
// -----------------------------------------------------------------------------
// dbus_bridge
//
// Purpose:
//   Data-bus bridge placed directly after the core's MEM-stage data port.
//   It decodes each 10-bit byte address and sends the access to one of two
//   places:
//     - the external data RAM, for 0x000-0x2FF;
//     - an internal peripheral block, for 0x300-0x3FF.
//   The peripheral block contains:
//     - an LED register;
//     - a two-flop synchronised switch input;
//     - an optional prescaled 32-bit compare timer with a sticky MATCH flag
//       and an interrupt output.
//   Read data is combinational because the core captures ddata_r at the end
//   of the MEM cycle.
//
// Peripheral map (word offsets inside 0x300-0x31F):
//   0x300 LEDS      R/W, low LED_W bits
//   0x304 SW        RO,  synchronised sw_in
//   0x308 COUNT     R/W  (timer)
//   0x30C CMP       R/W  (timer)
//   0x310 CTRL      bit0 EN, bit1 MATCH (write 1 clears), bit2 AUTORELOAD,
//                   bit3 IRQ_EN (timer)
//   0x314 PRESCALE  R/W, low 16 bits (timer)
//   All other offsets, including 0x320-0x3FF, read 0 and ignore writes.
//
// Configuration:
//   DBUS_TIMER_EN - define it to build the timer (COUNT, CMP, CTRL, PRESCALE
//                   and the prescaler). When it is undefined:
//                     - those offsets read 0 and ignore writes;
//                     - irq is tied to 0.
//
// Parameters:
//   LED_W  width of the LED register (1..32)
//   SW_W   width of the switch input (1..32)
//
// Ports:
//   CLK     single clock, rising edge
//   RESET   synchronous, active-high reset
//   bus     dbus_bridge_if.slave (core port and RAM port)
//   sw_in   asynchronous switch inputs
//   leds    LED register contents
//   irq     timer interrupt request (MATCH & IRQ_EN)
// -----------------------------------------------------------------------------
module dbus_bridge #(
  parameter int LED_W = 8,
  parameter int SW_W  = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  dbus_bridge_if.slave     bus,
  input  logic [SW_W-1:0]  sw_in,
  output logic [LED_W-1:0] leds,
  output logic             irq
);

  // Word offsets inside the peripheral window, taken from daddr[4:2].
  typedef enum logic [2:0] {
    REG_LEDS     = 3'd0,
    REG_SW       = 3'd1,
    REG_COUNT    = 3'd2,
    REG_CMP      = 3'd3,
    REG_CTRL     = 3'd4,
    REG_PRESCALE = 3'd5,
    REG_RSVD6    = 3'd6,
    REG_RSVD7    = 3'd7
  } reg_sel_e;

  logic        periph;
  logic        periph_hit;
  logic        periph_wr;
  reg_sel_e    reg_sel;
  logic [31:0] preg;
  logic        unused_addr_bits;

  // Address decode.
  //   - periph covers the whole 0x300-0x3FF window, so RAM writes are
  //     blocked for all of it.
  //   - periph_hit narrows this to the eight implemented word slots at
  //     0x300-0x31F.
  assign periph     = (bus.daddr[9:8] == 2'b11);
  assign periph_hit = periph && (bus.daddr[7:5] == 3'b000);
  assign periph_wr  = periph_hit && bus.d_rw;
  assign reg_sel    = reg_sel_e'(bus.daddr[4:2]);

  assign bus.ram_addr = bus.daddr[9:2];
  assign bus.ram_d    = bus.ddata_w;
  assign bus.ram_we   = bus.d_rw & ~periph;
  assign bus.ddata_r  = periph ? preg : bus.ram_q;

  // Only word accesses exist, so the byte-lane bits are deliberately dropped.
  assign unused_addr_bits = ^bus.daddr[1:0];

  // ---------------------------------------------------------------------------
  // LED register
  // ---------------------------------------------------------------------------
  logic [LED_W-1:0] led_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      led_q <= '0;
    end else if (periph_wr && (reg_sel == REG_LEDS)) begin
      led_q <= bus.ddata_w[LED_W-1:0];
    end
  end

  assign leds = led_q;

  // ---------------------------------------------------------------------------
  // Switch synchroniser: two flops. A change on sw_in becomes readable
  // after the second rising edge.
  // ---------------------------------------------------------------------------
  logic [SW_W-1:0] sw_meta;
  logic [SW_W-1:0] sw_sync;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

`ifdef DBUS_TIMER_EN
  // ---------------------------------------------------------------------------
  // Timer
  // ---------------------------------------------------------------------------
  logic [31:0] count_q;
  logic [31:0] cmp_q;
  logic [15:0] prescale_q;
  logic [15:0] pcnt_q;
  logic        en_q;
  logic        match_q;
  logic        autoreload_q;
  logic        irq_en_q;

  logic wr_count;
  logic wr_cmp;
  logic wr_ctrl;
  logic wr_prescale;
  logic tick;
  logic cmp_hit;

  assign wr_count    = periph_wr && (reg_sel == REG_COUNT);
  assign wr_cmp      = periph_wr && (reg_sel == REG_CMP);
  assign wr_ctrl     = periph_wr && (reg_sel == REG_CTRL);
  assign wr_prescale = periph_wr && (reg_sel == REG_PRESCALE);

  assign tick = en_q && (pcnt_q == prescale_q);

  // A software write to COUNT in a tick cycle suppresses the compare.
  // cmp_q is the registered value, so a CMP write in the same cycle
  // only affects later compares.
  assign cmp_hit = tick && !wr_count && (count_q == cmp_q);

  // Prescaler.
  //   - Sits at 0 while the timer is disabled.
  //   - Restarts on every PRESCALE write and after each tick.
  //   - Its period is therefore PRESCALE+1 cycles.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pcnt_q <= '0;
    end else if (!en_q || wr_prescale || tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + 16'd1;
    end
  end

  // Count register.
  //   - A software write has priority over the tick update.
  //   - On a tick it reloads to 0 only when the compare hits and
  //     AUTORELOAD is set; otherwise it increments and wraps naturally.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
    end else if (wr_count) begin
      count_q <= bus.ddata_w;
    end else if (tick) begin
      if (cmp_hit && autoreload_q) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  // Compare and prescale registers: plain software-writable storage.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmp_q      <= '0;
      prescale_q <= '0;
    end else begin
      if (wr_cmp) begin
        cmp_q <= bus.ddata_w;
      end
      if (wr_prescale) begin
        prescale_q <= bus.ddata_w[15:0];
      end
    end
  end

  // Control bits.
  //   - MATCH is sticky; a set from the hardware beats a write-1-clear
  //     from software in the same cycle.
  //   - Writing 0 to bit1 leaves MATCH unchanged.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      en_q         <= 1'b0;
      match_q      <= 1'b0;
      autoreload_q <= 1'b0;
      irq_en_q     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_q         <= bus.ddata_w[0];
        autoreload_q <= bus.ddata_w[2];
        irq_en_q     <= bus.ddata_w[3];
      end
      if (cmp_hit) begin
        match_q <= 1'b1;
      end else if (wr_ctrl && bus.ddata_w[1]) begin
        match_q <= 1'b0;
      end
    end
  end

  // Both sources are flops, so irq is glitch-free.
  assign irq = match_q & irq_en_q;
`else
  assign irq = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Peripheral read mux. COUNT returns the registered value, i.e. the value
  // before this cycle's update.
  // ---------------------------------------------------------------------------
  always_comb begin
    preg = '0;
    if (periph_hit) begin
      case (reg_sel)
        REG_LEDS:     preg = 32'(led_q);
        REG_SW:       preg = 32'(sw_sync);
`ifdef DBUS_TIMER_EN
        REG_COUNT:    preg = count_q;
        REG_CMP:      preg = cmp_q;
        REG_CTRL:     preg = {28'd0, irq_en_q, autoreload_q, match_q, en_q};
        REG_PRESCALE: preg = {16'd0, prescale_q};
`endif
        default:      preg = '0;
      endcase
    end
  end

endmodule

// File: doc/dbus_bridge.md
# dbus_bridge

Data-bus bridge sitting directly downstream of the pipelined core's MEM-stage data port (`daddr`, `ddata_w`, `d_rw`, `ddata_r`). It decodes each 10-bit byte address and routes the access either to the external data RAM or to an internal peripheral block. The peripheral block holds an LED output register, a synchronised switch input and a prescaled 32-bit compare timer with an interrupt flag. Read data is returned combinationally in the same cycle, because the core captures `ddata_r` into MEM/WB at the end of the MEM cycle.

## Interface
- `LED_W`, 8, width of the LED output register (1..32)
- `SW_W`, 8, width of the switch input (1..32)

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `daddr`  in  10  core data byte address
- `ddata_w`  in  32  core write data
- `d_rw`  in  1  core write enable (1 = write)
- `ddata_r`  out  32  read data to core, combinational
- `ram_addr`  out  8  RAM word address = `daddr[9:2]`
- `ram_d`  out  32  RAM write data = `ddata_w`
- `ram_we`  out  1  RAM write enable
- `ram_q`  in  32  RAM read data (asynchronous RAM)
- `sw_in`  in  SW_W  asynchronous switch inputs
- `leds`  out  LED_W  LED register contents
- `irq`  out  1  timer interrupt request

## Operation
- Decode:
  - `periph = (daddr[9:8] == 2'b11)`.
  - `ram_we = d_rw & ~periph`.
  - `ddata_r = periph ? preg : ram_q`.
  - `daddr[1:0]` is ignored; only word accesses are supported.
- Peripheral map (`daddr[4:2]` within 0x300–0x31F):
  - 0x300 LEDS: R/W, low LED_W bits, upper bits read 0.
  - 0x304 SW: read-only, output of a two-flop synchroniser on `sw_in`, zero-extended.
  - 0x308 COUNT: R/W, 32-bit timer count.
  - 0x30C CMP: R/W, 32-bit compare value.
  - 0x310 CTRL:
    - bit0 EN, R/W.
    - bit1 MATCH: sticky; write 1 clears it, write 0 has no effect.
    - bit2 AUTORELOAD, R/W.
    - bit3 IRQ_EN, R/W.
    - bits 31:4 read 0.
  - 0x314 PRESCALE: R/W, low 16 bits.
  - 0x318, 0x31C and all of 0x320–0x3FF: read 0, writes ignored.
- Prescaler:
  - 16-bit `pcnt`.
  - When EN=0, `pcnt` is held at 0.
  - When EN=1: `tick = (pcnt == PRESCALE)`. On tick, `pcnt` goes to 0; otherwise it increments.
  - A write to PRESCALE also clears `pcnt`.
  - PRESCALE=0 gives a tick every cycle.
- Timer, on a tick:
  - If COUNT == CMP: MATCH is set. COUNT goes to 0 if AUTORELOAD=1, else COUNT+1.
  - Otherwise COUNT goes to COUNT+1, wrapping 0xFFFFFFFF to 0.
- `irq = MATCH & IRQ_EN`.
- Simultaneous events:
  - A software write to COUNT in a tick cycle wins over the increment or reload; no match is evaluated that cycle.
  - A MATCH set and a write-1-clear in the same cycle: set wins.
  - A write to CMP in a tick cycle: the compare uses the old CMP.
- Reset (applies at any time, including mid-count): LEDS, the synchroniser, COUNT, CMP, CTRL, PRESCALE and `pcnt` all go to 0.

## Timing
- Reads:
  - Zero latency; `ddata_r` is valid in the same cycle as `daddr`.
  - A COUNT read returns the registered value, i.e. the value before this cycle's update.
- Writes: register contents change at the rising edge that ends the access cycle and are visible to a read in the next cycle.
- SW: a change on `sw_in` is readable 2 edges later.
- MATCH and `irq`: assert on the edge after the matching tick cycle.
- Values after reset:
  - `leds`=0, `irq`=0.
  - `ram_addr`, `ram_d`, `ram_we` and `ddata_r` follow their inputs combinationally.

## Configuration
- `DBUS_TIMER_EN` defined:
  - COUNT, CMP, CTRL, PRESCALE and the prescaler are implemented as described above.
- `DBUS_TIMER_EN` undefined:
  - None of that logic exists.
  - Offsets 0x308–0x314 read 0 and writes to them are ignored.
  - `irq` is tied to 0.
  - LEDS, SW and RAM routing are unchanged.

## Test plan
- RAM routing: write 0xDEADBEEF to daddr 0x044 → `ram_we`=1, `ram_addr`=0x11; daddr 0x300 with `d_rw`=1 → `ram_we`=0.
- LED/SW: write 0x1A5 to 0x300 → `leds`=0xA5 (LED_W=8) and a read returns 0xA5; `sw_in`=0x3C → a read of 0x304 returns 0x3C from the 2nd edge onward, 0 before.
- Timer compare:
  - Setup: PRESCALE=2, CMP=3, CTRL=0x9.
  - COUNT increments every 3 cycles.
  - MATCH and `irq` rise one cycle after the tick with COUNT=3, and COUNT becomes 4.
  - Writing 0x2 to CTRL drops `irq` on the next edge.
- Auto-reload and wrap:
  - CTRL=0x5, CMP=5, PRESCALE=0 → COUNT cycles 0..5,0,…
  - COUNT=0xFFFFFFFF, CMP=7, AUTORELOAD=0 → next value is 0 and MATCH stays 0.
- Collisions:
  - A write of COUNT=100 in a tick cycle → COUNT=100.
  - A write-1-clear of MATCH in a matching tick cycle → MATCH=1.
- Reset mid-count: assert RESET with COUNT=0x1234 and `irq`=1 → on the next edge all registers are 0, `irq`=0 and `leds`=0.
